// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and default bounds for the ROM download arbiter
package rom_dl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DL    = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } dl_state_e;

  localparam logic [2:0] REGION_NONE = 3'b000;
  localparam logic [2:0] REGION_CPU  = 3'b001;
  localparam logic [2:0] REGION_GFX  = 3'b010;
  localparam logic [2:0] REGION_PROM = 3'b100;

  localparam logic [15:0] CPU_END_DEF  = 16'h4000;
  localparam logic [15:0] GFX_END_DEF  = 16'h5000;
  localparam logic [15:0] PROM_END_DEF = 16'h5020;
  localparam int          HOLD_CYC_DEF = 16;

endpackage

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - byte address to one-hot ROM region plus in-range flag
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter logic [15:0] CPU_END  = CPU_END_DEF,
  parameter logic [15:0] GFX_END  = GFX_END_DEF,
  parameter logic [15:0] PROM_END = PROM_END_DEF
) (
  input  logic [15:0] addr,
  output logic [2:0]  region,
  output logic        in_range
);

  always_comb begin
    region = REGION_NONE;
    if (addr < CPU_END)       region = REGION_CPU;
    else if (addr < GFX_END)  region = REGION_GFX;
    else if (addr < PROM_END) region = REGION_PROM;
    in_range = (region != REGION_NONE);
  end

endmodule

// File: rtl/rom_dl_arbiter.sv
// rtl/rom_dl_arbiter.sv - shares the ROM store between HPS download and core fetch
module rom_dl_arbiter
  import rom_dl_pkg::*;
#(
  parameter logic [15:0] CPU_END  = CPU_END_DEF,
  parameter logic [15:0] GFX_END  = GFX_END_DEF,
  parameter logic [15:0] PROM_END = PROM_END_DEF,
  parameter int          HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ack,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [2:0]  region_sel,
  output logic        core_reset,
  output logic [15:0] dl_bytes
);

  localparam int             CW        = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0]  HOLD_INIT = CW'(HOLD_CYC);

  dl_state_e       state_q, state_d;
  logic [CW-1:0]   hold_cnt_q;
  logic            wb_full;
  logic [15:0]     wb_addr;
  logic [7:0]      wb_data;
  logic [2:0]      wb_region;
  logic            rd_wait;
  logic            rd_drop;

  logic [2:0]      dec_region;
  logic            dec_in_range;
  logic            fetch_busy;
  logic            capture;
  logic            wr_issue;
  logic            rd_issue;
  logic            we_accept;

  rom_region_decode #(
    .CPU_END  (CPU_END),
    .GFX_END  (GFX_END),
    .PROM_END (PROM_END)
  ) u_decode (
    .addr     (ioctl_addr[15:0]),
    .region   (dec_region),
    .in_range (dec_in_range)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HOLD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (ioctl_download) state_d = ST_DL;
      ST_DL:    if (!ioctl_download) state_d = ST_FLUSH;
      ST_FLUSH: if (!wb_full) state_d = ST_HOLD;
      ST_HOLD: begin
        if (ioctl_download)               state_d = ST_DL;
        else if (hold_cnt_q <= CW'(1))    state_d = ST_RUN;
      end
      default:  state_d = ST_HOLD;
    endcase
  end

  // A fetch caught by a download start is drained with its ack masked before any write goes out.
  always_comb begin
    fetch_busy = mem_rd | rd_wait;
    we_accept  = mem_we & mem_ready;
    cpu_ack    = rd_wait & mem_ready & ~rd_drop & (state_q == ST_RUN);
    capture    = (state_q == ST_DL) & ioctl_wr & ~wb_full &
                 (ioctl_addr[24:16] == 9'd0) & dec_in_range;
    wr_issue   = ((state_q == ST_DL) | (state_q == ST_FLUSH)) & ~fetch_busy & ~mem_we &
                 (wb_full | capture);
    rd_issue   = (state_q == ST_RUN) & cpu_req & ~fetch_busy & ~wb_full;
  end

  assign ioctl_wait = wb_full;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= HOLD_INIT;
      wb_full    <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_region  <= REGION_NONE;
      rd_wait    <= 1'b0;
      rd_drop    <= 1'b0;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      region_sel <= REGION_NONE;
      core_reset <= 1'b1;
      dl_bytes   <= '0;
    end else begin
      if (capture) begin
        wb_full   <= 1'b1;
        wb_addr   <= ioctl_addr[15:0];
        wb_data   <= ioctl_dout;
        wb_region <= dec_region;
      end else if (we_accept) begin
        wb_full   <= 1'b0;
      end

      // Writes come straight from the HPS bus when the buffer was empty, else from the buffer.
      if (wr_issue) begin
        mem_we     <= 1'b1;
        mem_addr   <= wb_full ? wb_addr   : ioctl_addr[15:0];
        mem_din    <= wb_full ? wb_data   : ioctl_dout;
        region_sel <= wb_full ? wb_region : dec_region;
      end else if (we_accept) begin
        mem_we     <= 1'b0;
      end

      if (rd_issue) begin
        mem_rd   <= 1'b1;
        mem_addr <= cpu_addr;
      end else if (mem_rd && mem_ready) begin
        mem_rd   <= 1'b0;
      end

      if (mem_rd && mem_ready)       rd_wait <= 1'b1;
      else if (rd_wait && mem_ready) rd_wait <= 1'b0;

      if (rd_wait && mem_ready)                   rd_drop <= 1'b0;
      else if (state_q != ST_RUN && fetch_busy)   rd_drop <= 1'b1;

      if (state_q != ST_DL && state_d == ST_DL)      dl_bytes <= '0;
      else if (we_accept && dl_bytes != 16'hFFFF)    dl_bytes <= dl_bytes + 16'd1;

      if (state_d == ST_DL)                              core_reset <= 1'b1;
      else if (state_q == ST_HOLD && state_d == ST_RUN)  core_reset <= 1'b0;

      if (state_q == ST_FLUSH && state_d == ST_HOLD)     hold_cnt_q <= HOLD_INIT;
      else if (state_q == ST_HOLD && hold_cnt_q != '0)   hold_cnt_q <= hold_cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// tb/tb_rom_dl_arbiter.sv - directed self-checking bench for rom_dl_arbiter
module tb_rom_dl_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ack;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [2:0]  region_sel;
  logic        core_reset;
  logic [15:0] dl_bytes;

  int total  = 0;
  int passed = 0;

  int we_cnt = 0, ack_cnt = 0, both_cnt = 0, data_err = 0;
  logic [15:0] last_we_addr = '0;
  logic [7:0]  last_we_din  = '0;
  logic [2:0]  reg_3fff = '0, reg_4000 = '0, reg_5000 = '0;
  logic        chk_data = 1'b0;

  int we0, a0, fall, wc, n;

  rom_dl_arbiter dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ack        (cpu_ack),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_rd         (mem_rd),
    .region_sel     (region_sel),
    .core_reset     (core_reset),
    .dl_bytes       (dl_bytes)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (mem_we && mem_rd) both_cnt <= both_cnt + 1;
    if (cpu_ack) ack_cnt <= ack_cnt + 1;
    if (mem_we && mem_ready) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_addr;
      last_we_din  <= mem_din;
      if (mem_addr == 16'h3FFF) reg_3fff <= region_sel;
      if (mem_addr == 16'h4000) reg_4000 <= region_sel;
      if (mem_addr == 16'h5000) reg_5000 <= region_sel;
      if (chk_data && mem_din != (mem_addr[7:0] ^ 8'h5A)) data_err <= data_err + 1;
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic hps_write(input logic [24:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (ioctl_wait && k < 100) begin step(); k++; end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (ioctl_wait && k < 50) begin step(); k++; end
  endtask

  task automatic wait_core_run(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (!core_reset && cyc == 0) cyc = i;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
    check({pfx, "_cpu_ack"},    32'(cpu_ack),    32'd0);
    check({pfx, "_mem_we"},     32'(mem_we),     32'd0);
    check({pfx, "_mem_rd"},     32'(mem_rd),     32'd0);
    check({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({pfx, "_mem_din"},    32'(mem_din),    32'd0);
    check({pfx, "_region_sel"}, 32'(region_sel), 32'd0);
    check({pfx, "_core_reset"}, 32'(core_reset), 32'd1);
    check({pfx, "_dl_bytes"},   32'(dl_bytes),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    cpu_req = 1'b0; cpu_addr = '0; mem_ready = 1'b1;
    repeat (3) step();
    check_reset_vals("por");

    // Power-up hold: core released on the 16th edge after reset
    reset_n = 1'b1;
    we0 = we_cnt;
    fall = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!core_reset && fall == 0) fall = i;
    end
    check("hold_len", 32'(fall), 32'd16);
    check("idle_no_we", 32'(we_cnt - we0), 32'd0);

    // Full image download
    ioctl_download = 1'b1;
    step();
    check("dl_core_reset", 32'(core_reset), 32'd1);
    check("dl_bytes_clr",  32'(dl_bytes),   32'd0);
    chk_data = 1'b1;
    we0 = we_cnt;
    for (int a = 0; a < 'h5020; a++) hps_write(25'(a), 8'(a) ^ 8'h5A);
    wait_idle();
    chk_data = 1'b0;
    ioctl_download = 1'b0;
    wait_core_run(fall);
    // one FLUSH cycle, then 16 HOLD cycles
    check("flush_hold_len", 32'(fall), 32'd18);
    check("full_we_cnt",    32'(we_cnt - we0), 32'h5020);
    check("full_dl_bytes",  32'(dl_bytes), 32'h5020);
    check("region_3fff",    32'(reg_3fff), 32'd1);
    check("region_4000",    32'(reg_4000), 32'd2);
    check("region_5000",    32'(reg_5000), 32'd4);
    check("full_data",      32'(data_err), 32'd0);

    // Out-of-range bytes are dropped silently
    ioctl_download = 1'b1;
    step();
    hps_write(25'h0001, 8'h11);
    hps_write(25'h0002, 8'h22);
    wait_idle();
    check("oor_pre_bytes", 32'(dl_bytes), 32'd2);
    we0 = we_cnt;
    hps_write(25'h05020, 8'h33);
    check("oor_5020_wait", 32'(ioctl_wait), 32'd0);
    hps_write(25'h10000, 8'h44);
    check("oor_10000_wait", 32'(ioctl_wait), 32'd0);
    step(); step();
    check("oor_no_we",  32'(we_cnt - we0), 32'd0);
    check("oor_bytes",  32'(dl_bytes), 32'd2);

    // Store stalled 5 cycles; a second strobe during wait is ignored
    we0 = we_cnt;
    ioctl_addr = 25'h0123; ioctl_dout = 8'hA5; ioctl_wr = 1'b1; mem_ready = 1'b0;
    wc = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ioctl_wait) wc++;
      ioctl_wr   = (i == 1);
      ioctl_addr = 25'h0456;
      ioctl_dout = 8'h99;
      mem_ready  = (i >= 5);
    end
    step(); step();
    check("stall_wait_cyc", 32'(wc), 32'd5);
    check("stall_we_cnt",   32'(we_cnt - we0), 32'd1);
    check("stall_we_addr",  32'(last_we_addr), 32'h0123);
    check("stall_we_din",   32'(last_we_din), 32'hA5);
    check("stall_bytes",    32'(dl_bytes), 32'd3);
    ioctl_download = 1'b0;
    wait_core_run(fall);
    check("flush_hold_len2", 32'(fall), 32'd18);

    // Core fetch in RUN
    a0 = ack_cnt;
    cpu_addr = 16'h1234; cpu_req = 1'b1;
    step();
    check("fetch_rd",      32'(mem_rd),   32'd1);
    check("fetch_addr",    32'(mem_addr), 32'h1234);
    check("fetch_ack_early", 32'(cpu_ack), 32'd0);
    step();
    check("fetch_rd_done", 32'(mem_rd),  32'd0);
    check("fetch_ack",     32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    step();
    check("fetch_ack_end", 32'(cpu_ack), 32'd0);
    check("fetch_ack_cnt", 32'(ack_cnt - a0), 32'd1);

    // Download starts with a fetch in flight
    a0 = ack_cnt; we0 = we_cnt;
    mem_ready = 1'b0; cpu_addr = 16'h2222; cpu_req = 1'b1;
    step();
    check("inflight_rd",   32'(mem_rd),   32'd1);
    check("inflight_addr", 32'(mem_addr), 32'h2222);
    ioctl_download = 1'b1;
    step();
    ioctl_addr = 25'h0010; ioctl_dout = 8'h77; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    check("inflight_no_we", 32'(mem_we),     32'd0);
    check("inflight_wait",  32'(ioctl_wait), 32'd1);
    mem_ready = 1'b1;
    n = 0;
    while (!mem_we && n < 20) begin step(); n++; end
    check("inflight_we_lat", 32'(n), 32'd3);
    check("inflight_we_addr", 32'(mem_addr), 32'h0010);
    check("inflight_we_din",  32'(mem_din),  32'h77);
    check("inflight_region",  32'(region_sel), 32'd1);
    step();
    cpu_req = 1'b0;
    check("inflight_no_ack", 32'(ack_cnt - a0), 32'd0);
    check("inflight_we_cnt", 32'(we_cnt - we0), 32'd1);
    check("never_we_and_rd", 32'(both_cnt), 32'd0);

    // Async reset in the middle of a download
    chk_data = 1'b1;
    for (int i = 0; i < 99; i++) hps_write(25'(16'h0100 + i), 8'(16'h0100 + i) ^ 8'h5A);
    wait_idle();
    chk_data = 1'b0;
    check("mid_bytes", 32'(dl_bytes), 32'd100);
    check("mid_data",  32'(data_err), 32'd0);
    ioctl_addr = 25'h0200; ioctl_dout = 8'h01; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
    check("mid_wait_full", 32'(ioctl_wait), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    ioctl_download = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("post_rst_hold", 32'(core_reset), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
